ycbcr_src_arbiter: RTL and testbench
====================================

# ycbcr_src_arbiter

- Frame-granular scheduler that shares one RGB→YCbCr converter between two free-running RGB video sources.
- Grants the converter to one source per frame, round-robin:
  - Only whole frames are forwarded (rising to falling vsync).
  - Frames from the non-granted source are dropped.
  - A blanking gap is inserted between frames so the converter pipeline drains.
- Sits between the camera/test-pattern front ends and the color-conversion stage of the sobel-detection chain.
- Emits a source tag aligned with the converter's output.

## Interface

Parameters:
- CVT_LAT, 3, converter latency in cycles; sets the depth of the tag delay line.
- GAP_CYC, 4, blank cycles after each forwarded frame; legal range 1..255.
- LOCK_TIMEOUT, 1000000, cycles to wait for a granted source's frame start; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- src_en  in  2  per-source enable; bit i enables source i.
- s0_img_vsync / s0_img_herf / s0_img_valid  in  1 each  source 0 timing.
- s0_img_red / s0_img_green / s0_img_blue  in  8 each  source 0 pixel.
- s1_img_vsync / s1_img_herf / s1_img_valid  in  1 each  source 1 timing.
- s1_img_red / s1_img_green / s1_img_blue  in  8 each  source 1 pixel.
- cvt_img_vsync / cvt_img_herf / cvt_img_valid  out  1 each  muxed stream to the converter.
- cvt_img_red / cvt_img_green / cvt_img_blue  out  8 each  muxed pixel to the converter.
- cur_src  out  1  currently granted source.
- busy  out  1  high in LOCK or PASS.
- frame_done  out  1  one-cycle pulse when a forwarded frame ends.
- post_src_id  out  1  source tag aligned with converter output.
- s0_frame_cnt / s1_frame_cnt / s0_drop_cnt / s1_drop_cnt  out  16 each  present only with FRAME_CNT_EN.

## Operation

- vsync is high for the whole frame. Per-source vs_d registers give the edges:
  - rise = vsync & ~vs_d.
  - fall = ~vsync & vs_d.
- Arbitration:
  - last_src resets to 1, so source 0 is granted first.
  - Choose ~last_src if enabled, else last_src if enabled, else stay in IDLE.
  - The choice is loaded into cur_src.
- States:
  - IDLE: outputs blank. If any source is enabled, arbitrate and go to LOCK.
  - LOCK: wait for rise on cur_src.
    - On rise: go to PASS, set last_src <= cur_src, and forward that cycle.
    - If src_en[cur_src] drops: go to IDLE.
    - If the wait counter reaches LOCK_TIMEOUT: set last_src <= cur_src and go to IDLE.
  - PASS: forward cur_src every cycle.
    - On fall: forward that cycle, then go to GAP.
    - Deasserting src_en mid-frame does not truncate the frame.
  - GAP: count GAP_CYC blank cycles, then arbitrate.
    - If a source is enabled, go directly to LOCK; otherwise go to IDLE.
- Forwarding enable: fwd = PASS | (LOCK & rise[cur_src]).
- Output registers:
  - cvt_* <= selected source inputs when fwd, else all zero.
  - A tag register captures cur_src alongside cvt_*.
- post_src_id is that tag delayed by a CVT_LAT-stage shift register.
- A source that is already mid-frame when granted is never partially passed; LOCK requires a rising edge.
- Dropped frame: any rise on a source while it is not being forwarded by fwd.

## Timing

- Reset values: all cvt_* = 0, cur_src = 0, busy = 0, frame_done = 0, post_src_id = 0, counters = 0, state = IDLE.
- Source → cvt_* latency is exactly 1 cycle, with pixel values unchanged.
- frame_done is registered and asserts in the same cycle cvt_img_vsync goes 1→0.
- Minimum blank on cvt_img_vsync between two frames: GAP_CYC cycles, plus LOCK wait.
- Timeout counter: 24-bit, cleared on entering LOCK.
- Simultaneous rise on both sources while in LOCK: only cur_src is forwarded; the other counts as dropped.
- rst mid-frame: outputs are zero the next cycle and state is IDLE. The interrupted frame is not resumed; the next grant waits for a fresh rise.

## Configuration

- FRAME_CNT_EN defined:
  - Adds per-source 16-bit forwarded-frame counters, incremented on the frame_done of that source.
  - Adds per-source 16-bit dropped-frame counters.
  - Counters wrap from 0xFFFF to 0 and are cleared by rst.
- FRAME_CNT_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan

- Reset, then src_en=2'b01, source 0 sending 4×2 frames:
  - First frame appears on cvt_* 1 cycle later with identical pixels.
  - cur_src=0 and post_src_id=0, CVT_LAT cycles after cvt_img_valid.
- src_en=2'b11, both sources sending continuously with frames offset:
  - Granted frames alternate 0,1,0,1.
  - At least GAP_CYC=4 zero cycles between frames on cvt_img_vsync.
  - frame_done pulses once per frame.
- Grant source 1 while its vsync is already high:
  - cvt_* stays 0 until the next rise of s1_img_vsync.
  - The partial frame never appears.
- src_en=2'b01 with source 0 silent, LOCK_TIMEOUT=100:
  - After 100 cycles, returns to IDLE; busy drops; re-grants source 0.
  - With src_en=2'b11, the timeout hands over to source 1 instead.
- rst pulsed for 1 cycle mid-PASS: all outputs 0 the next cycle, state IDLE, last_src=1.
- With FRAME_CNT_EN, both sources sending 10 frames in lockstep: s0_frame_cnt + s0_drop_cnt = 10, and the same holds for source 1.

Source files
------------

// File: rtl/ycbcr_src_arbiter.sv
// ycbcr_src_arbiter
//   Frame-granular round-robin scheduler sharing one RGB->YCbCr converter
//   between two free-running RGB sources. Only whole frames (vsync rise to
//   fall) of the granted source are forwarded; a blanking gap follows each
//   forwarded frame so the converter pipeline can drain.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   src_en[1:0]          per-source enable
//   s0_img_* / s1_img_*  source timing (vsync/herf/valid) and 8-bit RGB pixel
//   cvt_img_*            registered muxed stream to the converter
//   cur_src              currently granted source
//   busy                 high while waiting for a frame start or forwarding
//   frame_done           one-cycle pulse as cvt_img_vsync falls
//   post_src_id          source tag aligned with converter output (CVT_LAT delay)
//   s*_frame_cnt / s*_drop_cnt   16-bit wrap-around counters (FRAME_CNT_EN only)
//
// Optional feature macro: FRAME_CNT_EN
module ycbcr_src_arbiter #(
  parameter int unsigned CVT_LAT      = 3,
  parameter int unsigned GAP_CYC      = 4,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] src_en,
  input  logic       s0_img_vsync,
  input  logic       s0_img_herf,
  input  logic       s0_img_valid,
  input  logic [7:0] s0_img_red,
  input  logic [7:0] s0_img_green,
  input  logic [7:0] s0_img_blue,
  input  logic       s1_img_vsync,
  input  logic       s1_img_herf,
  input  logic       s1_img_valid,
  input  logic [7:0] s1_img_red,
  input  logic [7:0] s1_img_green,
  input  logic [7:0] s1_img_blue,
  output logic       cvt_img_vsync,
  output logic       cvt_img_herf,
  output logic       cvt_img_valid,
  output logic [7:0] cvt_img_red,
  output logic [7:0] cvt_img_green,
  output logic [7:0] cvt_img_blue,
  output logic       cur_src,
  output logic       busy,
  output logic       frame_done,
  output logic       post_src_id
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0] s0_frame_cnt,
  output logic [15:0] s1_frame_cnt,
  output logic [15:0] s0_drop_cnt,
  output logic [15:0] s1_drop_cnt
`endif
);

  localparam logic [23:0] TO_LAST  = 24'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_PASS, S_GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_vs_d;
  logic [1:0]  w_vs, w_rise, w_fall;
  logic        r_cur_src, r_last_src;
  logic [23:0] r_to_cnt;
  logic [7:0]  r_gap_cnt;
  logic        w_alt, w_pick, w_any_en;
  logic        w_grant, w_set_last, w_fwd, w_done;

  logic        r_vsync, r_herf, r_valid, r_frame_done, r_tag;
  logic [7:0]  r_red, r_green, r_blue;
  logic [CVT_LAT-1:0] r_tag_dly;

  logic        w_sel_vsync, w_sel_herf, w_sel_valid;
  logic [7:0]  w_sel_red, w_sel_green, w_sel_blue;

  assign w_vs     = {s1_img_vsync, s0_img_vsync};
  assign w_rise   = w_vs & ~r_vs_d;
  assign w_fall   = ~w_vs & r_vs_d;
  assign w_any_en = |src_en;
  assign w_alt    = ~r_last_src;
  // Prefer the source not served last; fall back to the same one.
  assign w_pick   = src_en[w_alt] ? w_alt : r_last_src;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_set_last  = 1'b0;
    w_fwd       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_en) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        if (w_rise[r_cur_src]) begin
          w_fwd       = 1'b1;
          w_set_last  = 1'b1;
          w_state_nxt = S_PASS;
        end else if (!src_en[r_cur_src]) begin
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          // Mark the silent source as served so the other one gets a turn.
          w_set_last  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PASS: begin
        w_fwd = 1'b1;
        if (w_fall[r_cur_src]) begin
          w_done      = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          if (w_any_en) begin
            w_grant     = 1'b1;
            w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (r_cur_src) begin
      w_sel_vsync = s1_img_vsync; w_sel_herf  = s1_img_herf;  w_sel_valid = s1_img_valid;
      w_sel_red   = s1_img_red;   w_sel_green = s1_img_green; w_sel_blue  = s1_img_blue;
    end else begin
      w_sel_vsync = s0_img_vsync; w_sel_herf  = s0_img_herf;  w_sel_valid = s0_img_valid;
      w_sel_red   = s0_img_red;   w_sel_green = s0_img_green; w_sel_blue  = s0_img_blue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      // Load current vsync so a frame already in progress is not seen as a rise.
      r_vs_d       <= w_vs;
      r_cur_src    <= 1'b0;
      r_last_src   <= 1'b1;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_vsync      <= 1'b0;
      r_herf       <= 1'b0;
      r_valid      <= 1'b0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_frame_done <= 1'b0;
      r_tag        <= 1'b0;
      r_tag_dly    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vs_d  <= w_vs;
      if (w_grant)    r_cur_src  <= w_pick;
      if (w_set_last) r_last_src <= r_cur_src;
      if (w_grant)                  r_to_cnt <= '0;
      else if (r_state == S_LOCK)   r_to_cnt <= r_to_cnt + 24'd1;
      if (w_done)                   r_gap_cnt <= '0;
      else if (r_state == S_GAP)    r_gap_cnt <= r_gap_cnt + 8'd1;
      if (w_fwd) begin
        r_vsync <= w_sel_vsync;
        r_herf  <= w_sel_herf;
        r_valid <= w_sel_valid;
        r_red   <= w_sel_red;
        r_green <= w_sel_green;
        r_blue  <= w_sel_blue;
      end else begin
        r_vsync <= 1'b0;
        r_herf  <= 1'b0;
        r_valid <= 1'b0;
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
      r_frame_done <= w_done;
      r_tag        <= r_cur_src;
      r_tag_dly[0] <= r_tag;
      for (int unsigned i = 1; i < CVT_LAT; i++) begin
        r_tag_dly[i] <= r_tag_dly[i-1];
      end
    end
  end

  assign cvt_img_vsync = r_vsync;
  assign cvt_img_herf  = r_herf;
  assign cvt_img_valid = r_valid;
  assign cvt_img_red   = r_red;
  assign cvt_img_green = r_green;
  assign cvt_img_blue  = r_blue;
  assign cur_src       = r_cur_src;
  assign busy          = (r_state == S_LOCK) || (r_state == S_PASS);
  assign frame_done    = r_frame_done;
  assign post_src_id   = r_tag_dly[CVT_LAT-1];

`ifdef FRAME_CNT_EN
  logic [15:0] r_s0_fcnt, r_s1_fcnt, r_s0_dcnt, r_s1_dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_fcnt <= '0;
      r_s1_fcnt <= '0;
      r_s0_dcnt <= '0;
      r_s1_dcnt <= '0;
    end else begin
      if (w_done && !r_cur_src) r_s0_fcnt <= r_s0_fcnt + 16'd1;
      if (w_done &&  r_cur_src) r_s1_fcnt <= r_s1_fcnt + 16'd1;
      if (w_rise[0] && !(w_fwd && !r_cur_src)) r_s0_dcnt <= r_s0_dcnt + 16'd1;
      if (w_rise[1] && !(w_fwd &&  r_cur_src)) r_s1_dcnt <= r_s1_dcnt + 16'd1;
    end
  end

  assign s0_frame_cnt = r_s0_fcnt;
  assign s1_frame_cnt = r_s1_fcnt;
  assign s0_drop_cnt  = r_s0_dcnt;
  assign s1_drop_cnt  = r_s1_dcnt;
`endif

endmodule

// File: tb/tb_ycbcr_src_arbiter.sv
// Testbench for ycbcr_src_arbiter: directed source frames, expected pixels
// queued at drive time and compared by an independent output monitor.
module tb_ycbcr_src_arbiter;

  localparam int unsigned CVT_LAT = 3;
  localparam int unsigned GAP_CYC = 4;
  localparam int unsigned LOCK_TO = 100;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FL = 1 + H * (W + 2);   // vsync-high cycles per frame

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] src_en;
  logic       vs[2], hf[2], vl[2];
  logic [7:0] rr[2], gg[2], bb[2];

  logic       cvt_vs, cvt_hf, cvt_vl;
  logic [7:0] cvt_r, cvt_g, cvt_b;
  logic       cur_src, busy, frame_done, post_src_id;
`ifdef FRAME_CNT_EN
  logic [15:0] s0_fc, s1_fc, s0_dc, s1_dc;
`endif

  ycbcr_src_arbiter #(.CVT_LAT(CVT_LAT), .GAP_CYC(GAP_CYC), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst(rst), .src_en(src_en),
    .s0_img_vsync(vs[0]), .s0_img_herf(hf[0]), .s0_img_valid(vl[0]),
    .s0_img_red(rr[0]), .s0_img_green(gg[0]), .s0_img_blue(bb[0]),
    .s1_img_vsync(vs[1]), .s1_img_herf(hf[1]), .s1_img_valid(vl[1]),
    .s1_img_red(rr[1]), .s1_img_green(gg[1]), .s1_img_blue(bb[1]),
    .cvt_img_vsync(cvt_vs), .cvt_img_herf(cvt_hf), .cvt_img_valid(cvt_vl),
    .cvt_img_red(cvt_r), .cvt_img_green(cvt_g), .cvt_img_blue(cvt_b),
    .cur_src(cur_src), .busy(busy), .frame_done(frame_done), .post_src_id(post_src_id)
`ifdef FRAME_CNT_EN
    , .s0_frame_cnt(s0_fc), .s1_frame_cnt(s1_fc), .s0_drop_cnt(s0_dc), .s1_drop_cnt(s1_dc)
`endif
  );

  typedef struct {
    logic       src;
    logic [7:0] r, g, b;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_no = 0;
  int   n_done = 0;

  // Source generator state
  int          dly[2], pos[2], nfr[2], fid[2], low[2];
  logic [31:0] mask[2];

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc_no);
  endtask

  task automatic start_src(input int s, input int d, input int n, input int lo, input logic [31:0] m);
    dly[s] = d; pos[s] = 0; nfr[s] = n; fid[s] = 0; low[s] = lo; mask[s] = m;
  endtask

  // Drives one cycle of both sources; call right after a negedge.
  task automatic step_drive();
    int   p;
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      vs[s] = 1'b0; hf[s] = 1'b0; vl[s] = 1'b0; rr[s] = '0; gg[s] = '0; bb[s] = '0;
      if (dly[s] > 0) begin
        dly[s]--;
      end else if (nfr[s] > 0) begin
        if (pos[s] < FL) begin
          vs[s] = 1'b1;
          if (pos[s] >= 1 && ((pos[s] - 1) % (W + 2)) < W) begin
            p = ((pos[s] - 1) / (W + 2)) * W + ((pos[s] - 1) % (W + 2));
            hf[s] = 1'b1;
            vl[s] = 1'b1;
            rr[s] = 8'(s * 128 + fid[s] * 16 + p);
            gg[s] = ~rr[s];
            bb[s] = rr[s] ^ 8'h5A;
            if (mask[s][fid[s]]) begin
              e.src = 1'(s); e.r = rr[s]; e.g = gg[s]; e.b = bb[s]; e.cyc = cyc_no;
              sb.push_back(e);
            end
          end
        end
        pos[s]++;
        if (pos[s] == FL + low[s]) begin
          pos[s] = 0;
          nfr[s]--;
          fid[s]++;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_drive();
    end
  endtask

  task automatic do_reset(input logic [1:0] en);
    @(negedge clk); rst = 1'b1; src_en = en; step_drive();
    @(negedge clk); step_drive();
    @(negedge clk); rst = 1'b0; step_drive();
  endtask

  // Output monitor / scoreboard consumer
  initial begin
    exp_t e;
    logic prev_vs = 1'b0;
    logic seen    = 1'b0;
    int   low_run = 0;
    logic hv[CVT_LAT+1];
    logic hs[CVT_LAT+1];
    for (int i = 0; i <= CVT_LAT; i++) begin hv[i] = 1'b0; hs[i] = 1'b0; end
    forever begin
      @(posedge clk);
      cyc_no++;
      #1;
      if (rst) begin
        prev_vs = 1'b0; seen = 1'b0; low_run = 0;
        for (int i = 0; i <= CVT_LAT; i++) begin hv[i] = 1'b0; hs[i] = 1'b0; end
      end else begin
        for (int i = CVT_LAT; i > 0; i--) begin hv[i] = hv[i-1]; hs[i] = hs[i-1]; end
        hv[0] = 1'b0; hs[0] = 1'b0;
        if (cvt_vl) begin
          if (sb.size() == 0) begin
            chk("unexpected_pixel", int'(cvt_vl), 0);
          end else begin
            e = sb.pop_front();
            chk("pixel_src_rgb", int'({cur_src, cvt_r, cvt_g, cvt_b}), int'({e.src, e.r, e.g, e.b}));
            chk("latency", cyc_no - e.cyc, 1);
            hv[0] = 1'b1; hs[0] = e.src;
          end
        end
        if (hv[CVT_LAT]) chk("post_src_id", int'(post_src_id), int'(hs[CVT_LAT]));
        if (prev_vs && !cvt_vs) begin
          chk("frame_done_at_fall", int'(frame_done), 1);
          n_done++;
          seen = 1'b1;
          low_run = 0;
        end else if (frame_done) begin
          chk("frame_done_spurious", int'(frame_done), 0);
        end
        if (!cvt_vs) low_run++;
        else if (!prev_vs && seen) chk("gap_ge_gapcyc", int'(low_run >= int'(GAP_CYC)), 1);
        prev_vs = cvt_vs;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, nb;
    rst = 1'b1;
    src_en = 2'b00;
    for (int s = 0; s < 2; s++) begin
      start_src(s, 0, 0, 0, 32'd0);
      vs[s] = 1'b0; hf[s] = 1'b0; vl[s] = 1'b0; rr[s] = '0; gg[s] = '0; bb[s] = '0;
    end

    // Reset state
    cyc(2);
    @(posedge clk); #1;
    chk("rst_cvt", int'({cvt_vs, cvt_hf, cvt_vl, cvt_r, cvt_g, cvt_b}), 0);
    chk("rst_cur_src", int'(cur_src), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_post_src_id", int'(post_src_id), 0);
`ifdef FRAME_CNT_EN
    chk("rst_counters", int'(s0_fc) + int'(s1_fc) + int'(s0_dc) + int'(s1_dc), 0);
`endif

    // Single enabled source: both frames pass, 1-cycle latency
    do_reset(2'b01);
    start_src(0, 3, 2, 10, 32'b11);
    d0 = n_done;
    cyc(70);
    chk("s1_frames", n_done - d0, 2);
    chk("s1_sb_empty", sb.size(), 0);

    // Both enabled, offset by 15 cycles: granted order 0,1,0,1
    do_reset(2'b11);
    start_src(0, 3, 4, 17, 32'b1001);
    start_src(1, 18, 5, 17, 32'b10010);
    d0 = n_done;
    cyc(200);
    chk("s2_frames", n_done - d0, 4);
    chk("s2_sb_empty", sb.size(), 0);

    // Source 1 already mid-frame when granted: partial frame never passes
    @(negedge clk); rst = 1'b1; src_en = 2'b10; step_drive();
    @(negedge clk); step_drive();
    start_src(1, 0, 2, 10, 32'b10);
    @(negedge clk); step_drive();
    @(negedge clk); step_drive();
    @(negedge clk); rst = 1'b0; step_drive();
    d0 = n_done;
    cyc(60);
    chk("s3_frames", n_done - d0, 1);
    chk("s3_sb_empty", sb.size(), 0);

    // Reset pulse mid-PASS
    do_reset(2'b11);
    start_src(0, 3, 2, 10, 32'b11);
    cyc(8);
    @(negedge clk); rst = 1'b1; mask[0][0] = 1'b0; step_drive();
    @(posedge clk); #1;
    chk("midrst_cvt", int'({cvt_vs, cvt_hf, cvt_vl, cvt_r, cvt_g, cvt_b}), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_cur_src", int'(cur_src), 0);
    @(negedge clk); rst = 1'b0; step_drive();
    d0 = n_done;
    @(posedge clk); #1;
    chk("postrst_grant_src0", int'(cur_src), 0);
    chk("postrst_busy", int'(busy), 1);
    cyc(50);
    chk("s5_frames", n_done - d0, 1);
    chk("s5_sb_empty", sb.size(), 0);

    // LOCK timeout, src_en=01: re-grants source 0
    for (int v = 0; v < 2; v++) begin
      @(negedge clk); rst = 1'b1; src_en = (v == 0) ? 2'b01 : 2'b11;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      nb = 0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        if (busy) nb++;
        else if (nb > 0) break;
      end
      chk("timeout_busy_cycles", nb, int'(LOCK_TO));
      chk("timeout_idle_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("timeout_regrant_busy", int'(busy), 1);
      chk("timeout_regrant_src", int'(cur_src), v);
    end

`ifdef FRAME_CNT_EN
    // Lockstep sources, 10 frames each: alternate forward/drop
    do_reset(2'b11);
    start_src(0, 3, 10, 10, 32'b0101010101);
    start_src(1, 3, 10, 10, 32'b1010101010);
    d0 = n_done;
    cyc(260);
    chk("ls_frames", n_done - d0, 10);
    chk("ls_sb_empty", sb.size(), 0);
    chk("ls_s0_sum", int'(s0_fc) + int'(s0_dc), 10);
    chk("ls_s1_sum", int'(s1_fc) + int'(s1_dc), 10);
    chk("ls_s0_fwd", int'(s0_fc), 5);
    chk("ls_s1_fwd", int'(s1_fc), 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
